matrix_serializer: RTL and testbench
====================================

# matrix_serializer

Read-side counterpart to the 3x4 matrix register bank. On `start` it snapshots all twelve element values and streams them out one per beat on a single `WIDTH`-bit bus. Beats use a valid/ready handshake, in column-major order (a11, a21, a31, a12, … a34), which matches the bit order of the bank's load vector. It sits between the matrix register bank and any narrow consumer (output port, checker, downstream multiplier stage).

## Interface
- `WIDTH`, 8, element width in bits
- `clk`  in  1  rising-edge clock
- `aclr`  in  1  asynchronous, active-low reset
- `a11in` … `a34in` (12 ports)  in  WIDTH  matrix element values, named as in the register bank
- `start`  in  1  request a snapshot-and-send; accepted only in IDLE
- `abort`  in  1  synchronous cancel; returns to IDLE
- `dout`  out  WIDTH  current element
- `dout_valid`  out  1  `dout`/`idx`/`last` are valid
- `dout_ready`  in  1  consumer accepts the beat
- `idx`  out  4  element index 0..11 (load-vector bit position)
- `last`  out  1  high with `dout_valid` on idx 11
- `busy`  out  1  high in SEND
- `done`  out  1  one-cycle pulse after the final beat is accepted

## Operation
- States:
  - IDLE: `busy`=0, `dout_valid`=0.
  - SEND: `busy`=1, `dout_valid`=1.
- IDLE & `start`:
  - Capture all 12 inputs into the snapshot on that edge.
  - Set `idx`=0 and go to SEND.
  - Input changes after capture do not affect the stream.
- SEND, beat = `dout_valid & dout_ready`:
  - On a beat with `idx`<11: `idx`+1.
  - On a beat with `idx`==11: go to IDLE, `done`=1 for the next cycle, `idx` returns to 0.
- No beat: `dout`, `idx`, `last` hold stable. `dout_valid` never drops before a beat.
- Element order (`idx` 0..11): a11, a21, a31, a12, a22, a32, a13, a23, a33, a14, a24, a34.
- `dout` = snapshot[`idx`]; `dout` = 0 whenever `dout_valid`=0.
- `start` in SEND: ignored, including in the cycle of the final beat.
- `abort`:
  - Takes priority over a beat and over `start` in the same cycle.
  - SEND → IDLE next edge, with no `done` pulse.
  - In IDLE, `abort` with `start` means the start is not accepted.
- Reset (`aclr`=0, any time, including mid-stream):
  - IDLE; `dout`=0, `dout_valid`=0, `idx`=0, `last`=0, `busy`=0, `done`=0; snapshot cleared to 0.

## Timing
- `start` sampled at edge N → `dout_valid`=1 with a11 during cycle N+1.
- All outputs are registered; no combinational path from `dout_ready` to any output.
- With `dout_ready` held high: 12 beats in cycles N+1..N+12, `done` in cycle N+13 (IDLE).
- `start` asserted in the `done` cycle is accepted, so back-to-back matrices run at one per 13 cycles.
- `last` = `dout_valid` & (`idx`==11), registered alongside `idx`.

## Structure
- Shared package `matrix_pkg`:
  - `MATRIX_ELEMS`=12, `ROWS`=3, `COLS`=4.
  - Element index constants `IDX_A11`..`IDX_A34` (0..11).
  - State enum {IDLE, SEND}.
  - The register-bank load-vector width can use the same constants.
- One sub-module, `matrix_elem_mux`: combinational 12:1 `WIDTH`-bit mux driven by the snapshot array and `idx`, feeding the `dout` register. The FSM, counter and snapshot stay in the top module.

## Test plan
- Reset then stream: load elements a11..a34 = 0x11, 0x21, 0x31, 0x12, 0x22, 0x32, 0x13, 0x23, 0x33, 0x14, 0x24, 0x34; pulse `start` with `dout_ready`=1 → beats in that exact order at idx 0..11 in consecutive cycles, `last` only on 0x34, `done` one cycle later.
- Backpressure: hold `dout_ready`=0 for 5 cycles at idx 4 → `dout`=0x22, `idx`=4 stable and `dout_valid` high throughout; the stream resumes with 0x32.
- Snapshot isolation: after `start`, change all inputs to 0xFF → all 12 beats still carry the original values.
- Back-to-back and ignored start: `start` held high throughout → the second matrix's first beat arrives in the cycle after `done`; total 26 cycles for 24 beats.
- Abort: `abort` at idx 6 with `dout_ready`=1 → no beat at idx 6, IDLE next cycle, `done` stays 0; the next `start` restarts at a11.
- Async reset mid-stream: drop `aclr` at idx 7 between clock edges → all outputs 0 immediately; after release, no beats until `start`.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants and types for the 3x4 matrix register bank and its serializer.
// Element indices follow the bank's column-major load-vector bit order.
package matrix_pkg;

  localparam int ROWS         = 3;
  localparam int COLS         = 4;
  localparam int MATRIX_ELEMS = ROWS * COLS;
  localparam int IDX_W        = 4;

  localparam int IDX_A11 = 0;
  localparam int IDX_A21 = 1;
  localparam int IDX_A31 = 2;
  localparam int IDX_A12 = 3;
  localparam int IDX_A22 = 4;
  localparam int IDX_A32 = 5;
  localparam int IDX_A13 = 6;
  localparam int IDX_A23 = 7;
  localparam int IDX_A33 = 8;
  localparam int IDX_A14 = 9;
  localparam int IDX_A24 = 10;
  localparam int IDX_A34 = 11;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_ELEMS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  // Width of the register bank's flat load vector for a given element width.
  function automatic int load_vec_width(input int width);
    return MATRIX_ELEMS * width;
  endfunction

  // 1-based (row, col) to load-vector element index.
  function automatic int elem_idx(input int row, input int col);
    return (col - 1) * ROWS + (row - 1);
  endfunction

endpackage

// File: rtl/matrix_elem_mux.sv
// Combinational 12:1 element selector; out-of-range selects return zero.
module matrix_elem_mux
  import matrix_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] elems_i [MATRIX_ELEMS],
  input  logic [IDX_W-1:0] sel_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives data_o and no latch is inferred.
    data_o = '0;
    for (int i = 0; i < MATRIX_ELEMS; i++) begin
      if (sel_i == i[IDX_W-1:0]) begin
        data_o = elems_i[i];
      end
    end
  end

endmodule

// File: rtl/matrix_serializer.sv
// Snapshots the 3x4 matrix on start and streams the twelve elements column-major
// over a valid/ready bus; all outputs come straight from flops.
module matrix_serializer
  import matrix_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic [WIDTH-1:0] a11in,
  input  logic [WIDTH-1:0] a12in,
  input  logic [WIDTH-1:0] a13in,
  input  logic [WIDTH-1:0] a14in,
  input  logic [WIDTH-1:0] a21in,
  input  logic [WIDTH-1:0] a22in,
  input  logic [WIDTH-1:0] a23in,
  input  logic [WIDTH-1:0] a24in,
  input  logic [WIDTH-1:0] a31in,
  input  logic [WIDTH-1:0] a32in,
  input  logic [WIDTH-1:0] a33in,
  input  logic [WIDTH-1:0] a34in,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [IDX_W-1:0] idx,
  output logic             last,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] elems  [MATRIX_ELEMS];
  logic [WIDTH-1:0] snap_q [MATRIX_ELEMS];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             capture;
  logic             beat;
  logic [IDX_W-1:0] next_idx;
  logic [WIDTH-1:0] mux_data;

  assign elems[IDX_A11] = a11in;
  assign elems[IDX_A21] = a21in;
  assign elems[IDX_A31] = a31in;
  assign elems[IDX_A12] = a12in;
  assign elems[IDX_A22] = a22in;
  assign elems[IDX_A32] = a32in;
  assign elems[IDX_A13] = a13in;
  assign elems[IDX_A23] = a23in;
  assign elems[IDX_A33] = a33in;
  assign elems[IDX_A14] = a14in;
  assign elems[IDX_A24] = a24in;
  assign elems[IDX_A34] = a34in;

  // The mux looks one element ahead so dout can be registered on the beat.
  assign next_idx = idx_q + IDX_W'(1);
  assign beat     = (state_q == SEND) && dout_ready;

  matrix_elem_mux #(
    .WIDTH(WIDTH)
  ) u_elem_mux (
    .elems_i(snap_q),
    .sel_i  (next_idx),
    .data_o (mux_data)
  );

  // NOTE: the snapshot is cleared on reset so a stale matrix can never be replayed.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      for (int i = 0; i < MATRIX_ELEMS; i++) begin
        snap_q[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < MATRIX_ELEMS; i++) begin
        snap_q[i] <= elems[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    last_d  = last_q;
    done_d  = 1'b0;
    capture = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          capture = 1'b1;
          state_d = SEND;
          idx_d   = '0;
          // Snapshot is not yet visible this cycle, so the first element bypasses it.
          dout_d  = elems[IDX_A11];
          last_d  = 1'b0;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          dout_d  = '0;
          last_d  = 1'b0;
        end else if (beat) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            dout_d  = '0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = next_idx;
            dout_d = mux_data;
            last_d = (next_idx == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dout_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign idx        = idx_q;
  assign last       = last_q;
  assign done       = done_q;

endmodule

// File: tb/tb_matrix_serializer.sv
// Scoreboard bench for matrix_serializer: a matrix-level model queues expected beats,
// a negedge monitor compares every cycle.
module tb_matrix_serializer;

  typedef struct {
    logic [7:0] data;
    int         idx;
    bit         last;
  } beat_t;

  logic       clk;
  logic       aclr;
  logic [7:0] a [3][4];
  logic       start, abort, dout_ready;
  logic [7:0] dout;
  logic       dout_valid, last, busy, done;
  logic [3:0] idx;

  int n_vec = 0;
  int n_err = 0;

  beat_t exp_q[$];
  bit    exp_done = 0;

  matrix_serializer #(.WIDTH(8)) dut (
    .clk(clk), .aclr(aclr),
    .a11in(a[0][0]), .a12in(a[0][1]), .a13in(a[0][2]), .a14in(a[0][3]),
    .a21in(a[1][0]), .a22in(a[1][1]), .a23in(a[1][2]), .a24in(a[1][3]),
    .a31in(a[2][0]), .a32in(a[2][1]), .a33in(a[2][2]), .a34in(a[2][3]),
    .start(start), .abort(abort),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .idx(idx), .last(last), .busy(busy), .done(done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: a matrix is a list of 12 column-major beats; start/abort/ready
  // are sampled on the rising edge exactly as the consumer sees them.
  always @(posedge clk) begin
    if (!aclr) begin
      exp_q.delete();
      exp_done = 0;
    end else begin
      exp_done = 0;
      if (exp_q.size() != 0) begin
        if (abort) begin
          exp_q.delete();
        end else if (dout_ready) begin
          beat_t b;
          b = exp_q.pop_front();
          if (b.last) exp_done = 1;
        end
      end else if (start && !abort) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 3; r++) begin
            beat_t b;
            b.data = a[r][c];
            b.idx  = c * 3 + r;
            b.last = (b.idx == 11);
            exp_q.push_back(b);
          end
        end
      end
    end
  end

  // Monitor: compare every output once per cycle, away from the rising edge.
  always @(negedge clk) begin
    if (!aclr) begin
      exp_q.delete();
      exp_done = 0;
    end
    if (exp_q.size() != 0) begin
      check("valid", int'(dout_valid), 1);
      check("busy", int'(busy), 1);
      check("dout", int'(dout), int'(exp_q[0].data));
      check("idx", int'(idx), exp_q[0].idx);
      check("last", int'(last), int'(exp_q[0].last));
      check("done_in_send", int'(done), 0);
    end else begin
      check("idle_valid", int'(dout_valid), 0);
      check("idle_busy", int'(busy), 0);
      check("idle_dout", int'(dout), 0);
      check("idle_idx", int'(idx), 0);
      check("idle_last", int'(last), 0);
      check("done", int'(done), int'(exp_done));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pattern();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        a[r][c] = 8'(((r + 1) << 4) | (c + 1));
  endtask

  task automatic wait_idx(input int target);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (dout_valid && idx == 4'(target)) ok = 1;
    end
    if (!ok) check("wait_idx_timeout", 0, 1);
  endtask

  initial begin
    int beats, dones, done_at;
    bit valid_at [27];

    aclr = 1; start = 0; abort = 0; dout_ready = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        a[r][c] = 8'h00;
    #2 aclr = 0;
    repeat (2) @(posedge clk);
    #1 aclr = 1;
    step();

    // Plain stream with ready held high.
    load_pattern();
    start = 1; dout_ready = 1;
    step();
    start = 0;
    repeat (15) step();

    // Backpressure at idx 4.
    start = 1;
    step();
    start = 0;
    wait_idx(4);
    dout_ready = 0;
    repeat (5) begin
      @(negedge clk);
      check("bp_dout", int'(dout), 8'h22);
      check("bp_idx", int'(idx), 4);
      check("bp_valid", int'(dout_valid), 1);
    end
    dout_ready = 1;
    @(negedge clk);
    check("bp_resume", int'(dout), 8'h32);
    repeat (12) step();

    // Snapshot isolation: inputs go to 0xFF right after capture.
    start = 1;
    step();
    start = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        a[r][c] = 8'hFF;
    repeat (15) step();

    // Back-to-back with start held high throughout.
    load_pattern();
    start = 1;
    @(posedge clk);
    beats = 0; dones = 0; done_at = -1;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      valid_at[i] = dout_valid;
      if (dout_valid && dout_ready) beats++;
      if (done) begin
        dones++;
        if (done_at < 0) done_at = i;
      end
    end
    #1 start = 0;
    check("b2b_beats", beats, 24);
    check("b2b_dones", dones, 2);
    check("b2b_done_cycle", done_at, 12);
    if (done_at >= 0 && done_at < 26) check("b2b_restart", int'(valid_at[done_at + 1]), 1);
    repeat (15) step();

    // Abort at idx 6, then restart from a11.
    start = 1;
    step();
    start = 0;
    wait_idx(6);
    abort = 1;
    @(posedge clk);
    #1 abort = 0;
    @(negedge clk);
    check("abort_valid", int'(dout_valid), 0);
    check("abort_done", int'(done), 0);
    start = 1;
    step();
    start = 0;
    @(negedge clk);
    check("restart_dout", int'(dout), 8'h11);
    check("restart_idx", int'(idx), 0);

    // Asynchronous reset between edges at idx 7.
    wait_idx(7);
    @(posedge clk);
    #2 aclr = 0;
    #1;
    check("rst_dout", int'(dout), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_idx", int'(idx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_last", int'(last), 0);
    @(posedge clk);
    #1 aclr = 1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_valid", int'(dout_valid), 0);
    end

    // Randomized traffic.
    repeat (400) begin
      step();
      dout_ready = ($urandom_range(3) != 0);
      start      = ($urandom_range(7) == 0);
      abort      = ($urandom_range(39) == 0);
      if ($urandom_range(3) == 0)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 4; c++)
            a[r][c] = 8'($urandom);
    end
    start = 0; abort = 0; dout_ready = 1;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
